// File: rtl/sram_bus_bridge_pkg.sv
// Shared definitions for the SRAM-port to request/response bus bridge:
// FSM state encoding, port indices and CTRL stall-bus position.
package sram_bus_bridge_pkg;

  localparam int BRIDGE_ST_W   = 3;
  // Bit of CTRL's stall bus that carries stallreq_from_mem.
  localparam int STALL_IDX_MEM = 3;

  localparam int   NUM_PORTS = 2;
  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  typedef enum logic [BRIDGE_ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_A  = 3'd1,
    ST_WAIT_A = 3'd2,
    ST_REQ_B  = 3'd3,
    ST_WAIT_B = 3'd4,
    ST_DONE   = 3'd5
  } bridge_st_e;

  function automatic logic st_is_req(input bridge_st_e s);
    return (s == ST_REQ_A) || (s == ST_REQ_B);
  endfunction

  function automatic logic st_is_wait(input bridge_st_e s);
    return (s == ST_WAIT_A) || (s == ST_WAIT_B);
  endfunction

endpackage

// File: rtl/sram_bus_bridge.sv
// Serialises the core's inst/data SRAM accesses onto one request/response bus,
// one outstanding transaction at a time, stalling the pipeline meanwhile.
module sram_bus_bridge
  import sram_bus_bridge_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_en,
  input  logic [DATA_W/8-1:0] inst_wen,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_en,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                stallreq_from_mem,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int   STRB_W = DATA_W / 8;
  localparam logic IDX_A  = DATA_FIRST ? PORT_DATA : PORT_INST;
  localparam logic IDX_B  = DATA_FIRST ? PORT_INST : PORT_DATA;

  typedef struct packed {
    logic              en;
    logic [STRB_W-1:0] wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } port_req_t;

  port_req_t         port_in [NUM_PORTS];
  port_req_t         port_q  [NUM_PORTS];
  logic [DATA_W-1:0] rdata_q [NUM_PORTS];

  bridge_st_e state, state_nxt;
  logic       any_en, latch, take_resp, b_pending, cur_sel;
  port_req_t  cur;

  assign port_in[PORT_INST] = '{en: inst_en, wen: inst_wen, addr: inst_addr, wdata: inst_wdata};
  assign port_in[PORT_DATA] = '{en: data_en, wen: data_wen, addr: data_addr, wdata: data_wdata};

  assign any_en    = inst_en | data_en;
  assign latch     = (state == ST_IDLE) && any_en;
  assign b_pending = port_q[IDX_B].en;
  assign cur_sel   = (state == ST_REQ_B || state == ST_WAIT_B) ? IDX_B : IDX_A;
  assign cur       = port_q[cur_sel];

  // A response counts in WAIT, or in REQ when it arrives together with the accept.
  assign take_resp = bus_data_ok &&
                     (st_is_wait(state) || (st_is_req(state) && bus_addr_ok));

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        port_q[p]  <= '0;
        rdata_q[p] <= '0;
      end else begin
        if (latch) port_q[p] <= port_in[p];
        if (take_resp && (cur_sel == 1'(p)) && ~|port_q[p].wen)
          rdata_q[p] <= bus_rdata;
      end
    end
  end

  assign inst_rdata = rdata_q[PORT_INST];
  assign data_rdata = rdata_q[PORT_DATA];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (any_en) state_nxt = port_in[IDX_A].en ? ST_REQ_A : ST_REQ_B;
      ST_REQ_A:
        if (take_resp)        state_nxt = b_pending ? ST_REQ_B : ST_DONE;
        else if (bus_addr_ok) state_nxt = ST_WAIT_A;
      ST_WAIT_A:
        if (take_resp) state_nxt = b_pending ? ST_REQ_B : ST_DONE;
      ST_REQ_B:
        if (take_resp)        state_nxt = ST_DONE;
        else if (bus_addr_ok) state_nxt = ST_WAIT_B;
      ST_WAIT_B:
        if (take_resp) state_nxt = ST_DONE;
      ST_DONE:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // DONE drops stall for one cycle so the pipeline moves past the held request.
  always_comb begin
    stallreq_from_mem = 1'b0;
    bus_req           = 1'b0;
    bus_we            = 1'b0;
    bus_wstrb         = '0;
    bus_addr          = '0;
    bus_wdata         = '0;
    case (state)
      ST_IDLE: stallreq_from_mem = any_en;
      ST_REQ_A, ST_REQ_B: begin
        stallreq_from_mem = 1'b1;
        bus_req           = 1'b1;
        bus_we            = |cur.wen;
        bus_wstrb         = cur.wen;
        bus_addr          = cur.addr;
        bus_wdata         = cur.wdata;
      end
      ST_WAIT_A, ST_WAIT_B: stallreq_from_mem = 1'b1;
      default: ;
    endcase
  end

endmodule
